// File: rtl/ctta_sequencer_if.sv
// Request / datapath / response bundle for ctta_sequencer.
// slave is the sequencer side; master is the requesters, datapath and response consumer.
interface ctta_sequencer_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [7:0] req_c;
  logic [1:0] req_ctrl;

  logic [3:0] dp_a;
  logic [3:0] dp_b;
  logic [3:0] dp_c;
  logic       dp_ctrl;
  logic [4:0] dp_q;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [4:0] rsp_q;

  modport master (
    output req_valid, req_a, req_b, req_c, req_ctrl, dp_q, rsp_ready,
    input  req_ready, dp_a, dp_b, dp_c, dp_ctrl, rsp_valid, rsp_id, rsp_q
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_ctrl, dp_q, rsp_ready,
    output req_ready, dp_a, dp_b, dp_c, dp_ctrl, rsp_valid, rsp_id, rsp_q
  );
endinterface

// File: rtl/ctta_sequencer.sv
// Two-requester round-robin sequencer sharing one CTTA datapath with a fixed
// LAT-cycle result latency; one operation in flight at a time.
module ctta_sequencer #(
  parameter int unsigned LAT = 1  // legal range 1..7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ctta_sequencer_if.slave        bus,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [2:0] LatCnt = LAT[2:0];

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;
  logic       owner_q, owner_d;
  logic [3:0] dp_a_q, dp_a_d;
  logic [3:0] dp_b_q, dp_b_d;
  logic [3:0] dp_c_q, dp_c_d;
  logic       dp_ctrl_q, dp_ctrl_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [4:0] rsp_q_q, rsp_q_d;

  logic       any_req;
  logic       winner;
  logic [1:0] req_ready;

  assign any_req = |bus.req_valid;
  // On a tie the requester that did not win last time goes first.
  assign winner  = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_c_d       = dp_c_q;
    dp_ctrl_d    = dp_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_q_d      = rsp_q_q;
    req_ready    = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (any_req && rst_n) begin
          req_ready    = winner ? 2'b10 : 2'b01;
          state_d      = StExec;
          cnt_d        = LatCnt;
          last_grant_d = winner;
          owner_d      = winner;
          dp_a_d       = winner ? bus.req_a[7:4] : bus.req_a[3:0];
          dp_b_d       = winner ? bus.req_b[7:4] : bus.req_b[3:0];
          dp_c_d       = winner ? bus.req_c[7:4] : bus.req_c[3:0];
          dp_ctrl_d    = winner ? bus.req_ctrl[1] : bus.req_ctrl[0];
        end
      end
      StExec: begin
        cnt_d = cnt_q - 3'd1;
        // dp_q is only trusted on the last EXEC cycle.
        if (cnt_q == 3'd1) begin
          rsp_q_d     = bus.dp_q;
          rsp_id_d    = owner_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      dp_a_q       <= 4'd0;
      dp_b_q       <= 4'd0;
      dp_c_q       <= 4'd0;
      dp_ctrl_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_q_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_c_q       <= dp_c_d;
      dp_ctrl_q    <= dp_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_q_q      <= rsp_q_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.dp_c      = dp_c_q;
  assign bus.dp_ctrl   = dp_ctrl_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = rsp_q_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_ctta_sequencer.sv
// Bench for ctta_sequencer at LAT=1 and LAT=4 against a timestamp-based
// transaction model; sel chooses which instance the stimulus drives.
module tb_ctta_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       sel = 1'b0;
  logic [1:0] rv = 2'b00;
  logic [7:0] ra = 8'd0, rb = 8'd0, rc = 8'd0;
  logic [1:0] rctl = 2'b00;
  logic       rrdy = 1'b1;
  logic [4:0] dpq = 5'd0;

  ctta_sequencer_if if1();
  ctta_sequencer_if if4();
  logic busy1, busy4;

  ctta_sequencer #(.LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1));
  ctta_sequencer #(.LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave), .busy(busy4));

  assign if1.req_valid = sel ? 2'b00 : rv;
  assign if4.req_valid = sel ? rv : 2'b00;
  assign if1.req_a = ra;  assign if4.req_a = ra;
  assign if1.req_b = rb;  assign if4.req_b = rb;
  assign if1.req_c = rc;  assign if4.req_c = rc;
  assign if1.req_ctrl = rctl;  assign if4.req_ctrl = rctl;
  assign if1.rsp_ready = sel ? 1'b1 : rrdy;
  assign if4.rsp_ready = sel ? rrdy : 1'b1;
  assign if1.dp_q = dpq;  assign if4.dp_q = dpq;

  logic [1:0] o_ready;
  logic       o_busy, o_rv, o_id, o_dctl;
  logic [4:0] o_q;
  logic [3:0] o_da, o_db, o_dc;
  assign o_ready = sel ? if4.req_ready : if1.req_ready;
  assign o_busy  = sel ? busy4 : busy1;
  assign o_rv    = sel ? if4.rsp_valid : if1.rsp_valid;
  assign o_id    = sel ? if4.rsp_id : if1.rsp_id;
  assign o_q     = sel ? if4.rsp_q : if1.rsp_q;
  assign o_da    = sel ? if4.dp_a : if1.dp_a;
  assign o_db    = sel ? if4.dp_b : if1.dp_b;
  assign o_dc    = sel ? if4.dp_c : if1.dp_c;
  assign o_dctl  = sel ? if4.dp_ctrl : if1.dp_ctrl;

  int checks = 0;
  int failures = 0;

  // Model: an operation is in flight from its accept cycle until the response handshake;
  // its response is visible from accept + lat + 1 onward.
  int         lat = 1;
  int         cyc = 0;
  bit         m_inflight = 1'b0;
  int         m_acc = 0;
  logic       m_lg = 1'b1;
  logic [3:0] m_a = 4'd0, m_b = 4'd0, m_c = 4'd0;
  logic       m_ctl = 1'b0;
  logic       m_id = 1'b0;
  logic [4:0] m_q = 5'd0;
  int         grants[$];

  function automatic logic [4:0] dp_fn(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic k);
    logic [4:0] s;
    if (k) s = 5'(a ^ b) + 5'(c);
    else   s = 5'(a) + 5'(b) + 5'(c);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic step();
    logic       any, win, exp_rv;
    logic [1:0] exp_rdy;
    any     = |rv;
    win     = (rv == 2'b11) ? ~m_lg : rv[1];
    exp_rdy = (!m_inflight && any) ? (win ? 2'b10 : 2'b01) : 2'b00;
    exp_rv  = m_inflight && (cyc >= m_acc + lat + 1);
    dpq     = (m_inflight && cyc == m_acc + lat) ? m_q : 5'($urandom);
    #1;
    chk("req_ready", 8'(o_ready), 8'(exp_rdy));
    chk("busy", 8'(o_busy), 8'(m_inflight));
    chk("rsp_valid", 8'(o_rv), 8'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 8'(o_id), 8'(m_id));
      chk("rsp_q", 8'(o_q), 8'(m_q));
    end
    chk("dp_a", 8'(o_da), 8'(m_a));
    chk("dp_b", 8'(o_db), 8'(m_b));
    chk("dp_c", 8'(o_dc), 8'(m_c));
    chk("dp_ctrl", 8'(o_dctl), 8'(m_ctl));
    if (o_ready != 2'b00) grants.push_back(int'(o_ready[1]));
    @(posedge clk);
    if (exp_rdy != 2'b00) begin
      m_inflight = 1'b1;
      m_acc      = cyc;
      m_lg       = win;
      m_id       = win;
      m_a        = win ? ra[7:4] : ra[3:0];
      m_b        = win ? rb[7:4] : rb[3:0];
      m_c        = win ? rc[7:4] : rc[3:0];
      m_ctl      = win ? rctl[1] : rctl[0];
      m_q        = dp_fn(m_a, m_b, m_c, m_ctl);
    end else if (exp_rv && rrdy) begin
      m_inflight = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    logic [1:0] save_rv;
    save_rv = rv;
    rv = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 8'(o_ready), 8'd0);
    chk("rst_busy", 8'(o_busy), 8'd0);
    chk("rst_rsp_valid", 8'(o_rv), 8'd0);
    chk("rst_rsp_q", 8'(o_q), 8'd0);
    chk("rst_rsp_id", 8'(o_id), 8'd0);
    chk("rst_dp", {o_da, o_db}, 8'd0);
    chk("rst_dp_c_ctrl", {3'd0, o_dctl, o_dc}, 8'd0);
    m_inflight = 1'b0;
    m_lg = 1'b1;
    m_a = 4'd0; m_b = 4'd0; m_c = 4'd0; m_ctl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv = save_rv;
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      rv   = 2'($urandom);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 8'($urandom);
      rctl = 2'($urandom);
      rrdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      step();
    end
    rv = 2'b00;
    rrdy = 1'b1;
    repeat (lat + 3) step();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Tie every cycle with rsp_ready high: grants alternate from requester 0.
    grants.delete();
    rv = 2'b11; ra = 8'h5a; rb = 8'h3c; rc = 8'h96; rctl = 2'b01; rrdy = 1'b1;
    repeat (13) step();
    rv = 2'b00;
    repeat (3) step();
    chk("rr_count", 8'(grants.size()), 8'd5);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("rr_order", 8'(grants[i]), 8'(i % 2));
    end

    // Single request from requester 0.
    rv = 2'b01; ra = 8'h04; rb = 8'h01; rc = 8'h09; rctl = 2'b00;
    step();
    rv = 2'b00;
    repeat (4) step();

    // Response stalled for 5 cycles while requester 1 waits.
    rv = 2'b01; ra = 8'h07; rb = 8'h02; rc = 8'h03; rrdy = 1'b0;
    step();
    rv = 2'b10; ra = 8'hd0; rb = 8'hc0; rc = 8'h90; rctl = 2'b10;
    repeat (6) step();
    rrdy = 1'b1;
    step();
    step();
    rv = 2'b00;
    repeat (3) step();

    // One-cycle pulse from requester 1 while busy must not be granted.
    rv = 2'b01; ra = 8'h01; rb = 8'h02; rc = 8'h03; rctl = 2'b00;
    step();
    rv = 2'b10;
    step();
    rv = 2'b00;
    repeat (3) step();
    rv = 2'b11;
    step();
    rv = 2'b00;
    repeat (4) step();

    // Reset while in EXEC aborts the operation.
    do_reset();
    rv = 2'b01; ra = 8'h03; rb = 8'h0d; rc = 8'h0d; rctl = 2'b00;
    step();
    rv = 2'b00;
    do_reset();
    repeat (4) step();
    rv = 2'b11;
    step();
    rv = 2'b00;
    repeat (4) step();

    rand_phase(300);

    // Switch to the LAT=4 instance.
    sel = 1'b1;
    lat = 4;
    do_reset();
    rv = 2'b10; ra = 8'hf0; rb = 8'h20; rc = 8'he0; rctl = 2'b10; rrdy = 1'b1;
    step();
    rv = 2'b00;
    repeat (7) step();

    rand_phase(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
